taillamp_sequencer: RTL

Parametrised tail-lamp animation sequencer for the LED bar. It adds a configurable LED count, step rate, lead-in delay and repeat count, plus live left/right channel masking, a busy/done status pair and a re-armable start. It sits between the board push-buttons/switches and the red LED bank and 7-segment digit. On a start press it waits a lead-in time, plays a centre-out/outer-in frame a fixed number of times, and shows the remaining repeats on the digit.

---
 rtl/taillamp_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/taillamp_sequencer.sv
// taillamp_sequencer: lead-in delay, then centre-out/outer-in LED frames
// repeated a fixed count, remaining repeats shown on a 7-segment digit.
module taillamp_sequencer #(
  parameter int N_LEDS     = 10,
  parameter int TICK_DIV   = 5000000,
  parameter int LEAD_TICKS = 20,
  parameter int REPEATS    = 9
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              start_n,
  input  logic [1:0]        mode,
  output logic [N_LEDS-1:0] led,
  output logic [7:0]        seg_n,
  output logic              busy,
  output logic              done
);
  localparam int H    = N_LEDS / 2;
  localparam int F    = 2 * H + 3;
  localparam int SMAX = (F > LEAD_TICKS) ? F : LEAD_TICKS;
  localparam int SW   = $clog2(SMAX + 1);
  localparam int PW   = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    IDLE, LEAD, RUN, DONE
  } state_t;

  state_t          state;
  logic [SW-1:0]   step;
  logic [PW-1:0]   pre;
  logic [3:0]      rep;
  logic            s1, s2, s3;
  logic            start_ev;
  logic            tick;

  function automatic logic [N_LEDS-1:0] frame(
    input logic [SW-1:0] s,
    input logic [1:0]    m
  );
    logic [N_LEDS-1:0] p;
    int si;
    int k;
    p  = '0;
    si = int'(s);
    for (int i = 0; i < N_LEDS; i++) begin
      if (si < H) begin
        k    = si + 1;
        p[i] = (i >= H - k) && (i < H + k);
      end else if (si > H && si <= 2 * H) begin
        k    = si - H;
        p[i] = (i < k) || (i >= N_LEDS - k);
      end
    end
    case (m)
      2'b01:   p[N_LEDS-1:H] = '0;
      2'b10:   p[H-1:0] = '0;
      2'b11:   p = '0;
      default: ;
    endcase
    return p;
  endfunction

  function automatic logic [7:0] digit(input logic [3:0] r);
    logic [6:0] g;
    case (r)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      default: g = 7'h7F;
    endcase
    return {1'b1, g};
  endfunction

  // s3 holds the previous synchronised level for falling-edge detection
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      {s1, s2, s3} <= 3'b111;
    end else begin
      {s1, s2, s3} <= {start_n, s1, s2};
    end
  end

  assign start_ev = s3 & ~s2;
  assign tick     = (pre == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      led   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      rep   <= 4'(REPEATS);
      seg_n <= digit(4'(REPEATS));
      step  <= '0;
      pre   <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start_ev) begin
            state <= LEAD;
            rep   <= 4'(REPEATS);
            seg_n <= digit(4'(REPEATS));
            step  <= '0;
            pre   <= '0;
            led   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        LEAD: begin
          pre <= tick ? '0 : pre + 1'b1;
          if (tick) begin
            if (step == SW'(LEAD_TICKS - 1)) begin
              state <= RUN;
              step  <= '0;
              led   <= frame('0, mode);
            end else begin
              step <= step + 1'b1;
            end
          end
        end
        RUN: begin
          pre <= tick ? '0 : pre + 1'b1;
          if (tick) begin
            if (step != SW'(F - 1)) begin
              step <= step + 1'b1;
              led  <= frame(step + 1'b1, mode);
            end else if (rep > 4'd1) begin
              rep   <= rep - 1'b1;
              seg_n <= digit(rep - 1'b1);
              step  <= '0;
              led   <= frame('0, mode);
            end else begin
              rep   <= 4'd0;
              seg_n <= digit(4'd0);
              led   <= '0;
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
